// File: rtl/lfsr_seq_ctrl.sv
// Drives an external negedge 8-bit shift register as an LFSR: load seed, shift N times, capture result.
// Latency: N+1 cycles start-to-done; new start accepted every N+3 cycles.
module lfsr_seq_ctrl (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic [7:0] i_seed,
    input  logic [7:0] i_steps,
    input  logic [7:0] i_q,
    output logic [2:0] o_ctr,
    output logic [7:0] o_load_val,
    output logic       o_in_data,
    output logic       o_busy,
    output logic       o_done,
    output logic [7:0] o_rnd
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

    localparam logic [2:0] CTR_CLR  = 3'd0;
    localparam logic [2:0] CTR_LOAD = 3'd1;
    localparam logic [2:0] CTR_SHR  = 3'd5;

    state_t     r_state, w_state_nxt;
    logic [2:0] r_ctr, w_ctr_nxt;
    logic [7:0] r_load_val, w_load_val_nxt;
    logic [7:0] r_cnt, w_cnt_nxt;
    logic [7:0] r_rnd, w_rnd_nxt;
    logic       r_busy, w_busy_nxt;
    logic       r_done, w_done_nxt;

    always_comb begin
        w_state_nxt    = r_state;
        w_ctr_nxt      = r_ctr;
        w_load_val_nxt = r_load_val;
        w_cnt_nxt      = r_cnt;
        w_rnd_nxt      = r_rnd;
        w_busy_nxt     = r_busy;
        w_done_nxt     = r_done;
        case (r_state)
            S_IDLE: begin
                // The shift register has no hold code, so idling reloads the current result.
                w_ctr_nxt      = CTR_LOAD;
                w_load_val_nxt = r_rnd;
                w_busy_nxt     = 1'b0;
                w_done_nxt     = 1'b0;
                if (i_start) begin
                    w_state_nxt    = S_LOAD;
                    w_load_val_nxt = (i_seed == 8'h00) ? 8'h01 : i_seed;
                    w_cnt_nxt      = i_steps;
                    w_busy_nxt     = 1'b1;
                end
            end
            S_LOAD: begin
                w_state_nxt = S_RUN;
                w_ctr_nxt   = CTR_SHR;
            end
            S_RUN: begin
                // A loaded count of 0 wraps to 255 here, giving a 256-step run.
                w_cnt_nxt = r_cnt - 8'd1;
                w_ctr_nxt = CTR_SHR;
                if (r_cnt == 8'd1) begin
                    w_state_nxt    = S_DONE;
                    w_rnd_nxt      = i_q;
                    w_load_val_nxt = i_q;
                    w_ctr_nxt      = CTR_LOAD;
                    w_done_nxt     = 1'b1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_ctr_nxt   = CTR_LOAD;
                w_done_nxt  = 1'b0;
                w_busy_nxt  = 1'b0;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_ctr      <= CTR_CLR;
            r_load_val <= 8'h00;
            r_cnt      <= 8'h00;
            r_rnd      <= 8'h00;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ctr      <= w_ctr_nxt;
            r_load_val <= w_load_val_nxt;
            r_cnt      <= w_cnt_nxt;
            r_rnd      <= w_rnd_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
        end
    end

    assign o_in_data  = i_q[0] ^ i_q[2] ^ i_q[3] ^ i_q[4];
    assign o_ctr      = r_ctr;
    assign o_load_val = r_load_val;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_rnd      = r_rnd;

endmodule
